ifm_scan_ctrl: RTL and testbench



---
 rtl/ifm_scan_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_ifm_scan_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_scan_ctrl.sv
// ----------------------------------------------------------------------------
// ifm_scan_ctrl
//
// Transmit side of the IFM window-buffer command interface. Walks a 3x3
// window over an IFM_H x IFM_W input feature map in serpentine order, reads
// the needed pixels from a 3-port IFM memory and drives the window buffer's
// ifm_read command plus three packed row words. Each new window is handed to
// the PE array with a win_valid / pe_ready handshake.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   start, base_addr      : scan start pulse and byte address of pixel (0,0)
//   mem_ren               : read enable shared by the three memory ports
//   mem_addr0..2          : byte address per read port
//   mem_rdata0..2         : read data, valid one cycle after mem_ren
//   ifm_read              : window-buffer command (ALL/RIGHT/DOWN/LEFT/KEEP)
//   ifm_input0..2         : packed pixels in [23:0], [31:24] always zero
//   win_valid, pe_ready   : window handshake towards the PE array
//   win_row, win_col      : top-left position of the current window
//   busy, done            : scan in progress / last window accepted
// ----------------------------------------------------------------------------
module ifm_scan_ctrl #(
    parameter int IFM_H  = 8,
    parameter int IFM_W  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr0,
    output logic [ADDR_W-1:0] mem_addr1,
    output logic [ADDR_W-1:0] mem_addr2,
    input  logic [7:0]        mem_rdata0,
    input  logic [7:0]        mem_rdata1,
    input  logic [7:0]        mem_rdata2,
    output logic [2:0]        ifm_read,
    output logic [31:0]       ifm_input0,
    output logic [31:0]       ifm_input1,
    output logic [31:0]       ifm_input2,
    output logic              win_valid,
    input  logic              pe_ready,
    output logic [15:0]       win_row,
    output logic [15:0]       win_col,
    output logic              busy,
    output logic              done
);

    localparam int OH = IFM_H - 2;
    localparam int OW = IFM_W - 2;

    localparam logic [2:0] CMD_KEEP  = 3'b000;
    localparam logic [2:0] CMD_RIGHT = 3'b001;
    localparam logic [2:0] CMD_DOWN  = 3'b010;
    localparam logic [2:0] CMD_LEFT  = 3'b100;
    localparam logic [2:0] CMD_ALL   = 3'b111;

    // Last window: bottom row, at the right edge if the bottom row is an even
    // (left-to-right) row index, otherwise back at the left edge.
    localparam logic [15:0] LAST_ROW = 16'(OH - 1);
    localparam logic [15:0] COL_MAX  = 16'(OW - 1);
    localparam logic [15:0] LAST_COL = ((OH % 2) == 1) ? COL_MAX : 16'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_HOLD,
        S_FETCH
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        ld_cnt;
    logic [15:0]       row, col;
    logic [15:0]       row_nxt, col_nxt;
    logic [ADDR_W-1:0] base;
    logic [2:0]        move, move_nxt;
    logic [2:0][7:0]   stage0, stage1;
    logic [2:0][7:0]   rdata;
    logic [2:0][ADDR_W-1:0] addr;
    logic [2:0][31:0]  inp;
    logic              hs, last;

    assign rdata = {mem_rdata2, mem_rdata1, mem_rdata0};

    assign hs   = (state == S_HOLD) && pe_ready;
    assign last = (row == LAST_ROW) && (col == LAST_COL);

    // Byte address of pixel (r,c); wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] b,
                                                   input logic [31:0] r,
                                                   input logic [31:0] c);
        logic [31:0] off;
        off = r * 32'(IFM_W) + c;
        return b + ADDR_W'(off);
    endfunction

    // Serpentine move choice for the window after the current one.
    always_comb begin
        move_nxt = CMD_DOWN;
        row_nxt  = row;
        col_nxt  = col;
        if (!row[0] && (col < COL_MAX)) begin
            move_nxt = CMD_RIGHT;
            col_nxt  = col + 16'd1;
        end else if (row[0] && (col != 16'd0)) begin
            move_nxt = CMD_LEFT;
            col_nxt  = col - 16'd1;
        end else begin
            row_nxt  = row + 16'd1;
        end
    end

    // Next state and all command-side outputs.
    always_comb begin
        state_nxt = state;
        mem_ren   = 1'b0;
        addr      = '0;
        ifm_read  = CMD_KEEP;
        inp       = '0;
        win_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                mem_ren = 1'b1;
                for (int k = 0; k < 3; k++)
                    addr[k] = pix_addr(base, 32'(row) + 32'(k), 32'(col) + 32'(ld_cnt));
                if (ld_cnt == 2'd2) state_nxt = S_ISSUE;
            end
            S_FETCH: begin
                mem_ren = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    case (move)
                        CMD_RIGHT: addr[k] = pix_addr(base, 32'(row) + 32'(k), 32'(col) + 32'd2);
                        CMD_LEFT:  addr[k] = pix_addr(base, 32'(row) + 32'(k), 32'(col));
                        default:   addr[k] = pix_addr(base, 32'(row) + 32'd2, 32'(col) + 32'(k));
                    endcase
                end
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                // The final column's bytes arrive this cycle straight from
                // memory; the first two columns of a full load are staged.
                case (move)
                    CMD_ALL: begin
                        ifm_read = CMD_ALL;
                        for (int k = 0; k < 3; k++)
                            inp[k] = {8'h00, stage0[k], stage1[k], rdata[k]};
                    end
                    CMD_RIGHT: begin
                        ifm_read = CMD_RIGHT;
                        for (int k = 0; k < 3; k++)
                            inp[k] = {24'h0, rdata[k]};
                    end
                    CMD_LEFT: begin
                        ifm_read = CMD_LEFT;
                        for (int k = 0; k < 3; k++)
                            inp[k] = {8'h00, rdata[k], 16'h0};
                    end
                    CMD_DOWN: begin
                        ifm_read = CMD_DOWN;
                        inp[2]   = {8'h00, rdata[0], rdata[1], rdata[2]};
                    end
                    default: ifm_read = CMD_KEEP;
                endcase
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                win_valid = 1'b1;
                if (pe_ready) state_nxt = last ? S_IDLE : S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            ld_cnt <= 2'd0;
            row    <= 16'd0;
            col    <= 16'd0;
            base   <= '0;
            move   <= CMD_KEEP;
            stage0 <= '0;
            stage1 <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= hs && last;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base   <= base_addr;
                        row    <= 16'd0;
                        col    <= 16'd0;
                        ld_cnt <= 2'd0;
                        move   <= CMD_ALL;
                    end
                end
                S_LOAD: begin
                    ld_cnt <= ld_cnt + 2'd1;
                    // Read data trails the request by one cycle.
                    if (ld_cnt == 2'd1) stage0 <= rdata;
                    if (ld_cnt == 2'd2) stage1 <= rdata;
                end
                S_HOLD: begin
                    if (pe_ready && !last) begin
                        row  <= row_nxt;
                        col  <= col_nxt;
                        move <= move_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr0  = addr[0];
    assign mem_addr1  = addr[1];
    assign mem_addr2  = addr[2];
    assign ifm_input0 = inp[0];
    assign ifm_input1 = inp[1];
    assign ifm_input2 = inp[2];
    assign win_row    = row;
    assign win_col    = col;
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_ifm_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ifm_scan_ctrl
//
// Directed bench for ifm_scan_ctrl. Three instances cover a 4x4, a 3x3 and a
// 5x4 map. The memory model returns (addr - model base) as pixel data, so a
// pixel at (r,c) reads back r*IFM_W + c.
// ----------------------------------------------------------------------------
module tb_ifm_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pe_ready = 1'b1;
    logic [15:0] base_addr = 16'h0;
    logic [15:0] mdl_base = 16'h0;

    logic        st   [3];
    logic        ren  [3];
    logic [15:0] addr [3][3];
    logic [7:0]  rdata[3][3];
    logic [2:0]  cmd  [3];
    logic [31:0] inp  [3][3];
    logic        wv   [3];
    logic        bsy  [3];
    logic        dn   [3];
    logic [15:0] wr   [3];
    logic [15:0] wc   [3];

    int n_chk = 0;
    int n_err = 0;

    logic [2:0]  cmd_q[$];
    logic [31:0] i0_q[$], i1_q[$], i2_q[$];
    logic [15:0] last_row, last_col;
    int          hs;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int H = (g == 2) ? 5 : ((g == 1) ? 3 : 4);
        localparam int W = (g == 1) ? 3 : 4;
        ifm_scan_ctrl #(.IFM_H(H), .IFM_W(W), .ADDR_W(16)) u_dut (
            .clk(clk), .rst(rst), .start(st[g]), .base_addr(base_addr),
            .mem_ren(ren[g]),
            .mem_addr0(addr[g][0]), .mem_addr1(addr[g][1]), .mem_addr2(addr[g][2]),
            .mem_rdata0(rdata[g][0]), .mem_rdata1(rdata[g][1]), .mem_rdata2(rdata[g][2]),
            .ifm_read(cmd[g]),
            .ifm_input0(inp[g][0]), .ifm_input1(inp[g][1]), .ifm_input2(inp[g][2]),
            .win_valid(wv[g]), .pe_ready(pe_ready),
            .win_row(wr[g]), .win_col(wc[g]),
            .busy(bsy[g]), .done(dn[g])
        );
    end

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++)
            for (int k = 0; k < 3; k++)
                if (ren[g]) rdata[g][k] <= 8'(addr[g][k] - mdl_base);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_scan(input int i, input logic [15:0] b);
        base_addr = b;
        mdl_base  = b;
        st[i] = 1'b1;
        tick();
        st[i] = 1'b0;
    endtask

    task automatic chk_reset(input int i, input string tag);
        chk({tag, "_ren"},  32'(ren[i]), 0);
        chk({tag, "_a0"},   32'(addr[i][0]), 0);
        chk({tag, "_a1"},   32'(addr[i][1]), 0);
        chk({tag, "_a2"},   32'(addr[i][2]), 0);
        chk({tag, "_cmd"},  32'(cmd[i]), 0);
        chk({tag, "_in0"},  inp[i][0], 0);
        chk({tag, "_in1"},  inp[i][1], 0);
        chk({tag, "_in2"},  inp[i][2], 0);
        chk({tag, "_wv"},   32'(wv[i]), 0);
        chk({tag, "_busy"}, 32'(bsy[i]), 0);
        chk({tag, "_done"}, 32'(dn[i]), 0);
        chk({tag, "_row"},  32'(wr[i]), 0);
        chk({tag, "_col"},  32'(wc[i]), 0);
    endtask

    // Called in cycle 1 (start sampled in cycle 0); returns in cycle 5.
    task automatic check_first(input int i, input string tag,
                               input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                               input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        chk({tag, "_ren_c1"}, 32'(ren[i]), 1);
        chk({tag, "_a0_c1"}, 32'(addr[i][0]), 32'(a0));
        chk({tag, "_a1_c1"}, 32'(addr[i][1]), 32'(a1));
        chk({tag, "_a2_c1"}, 32'(addr[i][2]), 32'(a2));
        chk({tag, "_busy_c1"}, 32'(bsy[i]), 1);
        tick();
        chk({tag, "_ren_c2"}, 32'(ren[i]), 1);
        chk({tag, "_a0_c2"}, 32'(addr[i][0]), 32'(16'(a0 + 16'd1)));
        tick();
        chk({tag, "_ren_c3"}, 32'(ren[i]), 1);
        chk({tag, "_a2_c3"}, 32'(addr[i][2]), 32'(16'(a2 + 16'd2)));
        tick();
        chk({tag, "_ren_c4"}, 32'(ren[i]), 0);
        chk({tag, "_cmd_c4"}, 32'(cmd[i]), 32'h7);
        chk({tag, "_in0_c4"}, inp[i][0], e0);
        chk({tag, "_in1_c4"}, inp[i][1], e1);
        chk({tag, "_in2_c4"}, inp[i][2], e2);
        chk({tag, "_wv_c4"}, 32'(wv[i]), 0);
        tick();
        chk({tag, "_wv_c5"}, 32'(wv[i]), 1);
        chk({tag, "_row_c5"}, 32'(wr[i]), 0);
        chk({tag, "_col_c5"}, 32'(wc[i]), 0);
    endtask

    // Runs from the current cycle until done, recording issued commands and
    // handshakes. With restart set, a new start is pulsed in the done cycle.
    task automatic run_to_done(input int i, input string tag, input int budget,
                               input bit restart, output int nhs);
        bit got_done;
        int bad;
        got_done = 1'b0;
        bad = 0;
        nhs = 0;
        cmd_q.delete(); i0_q.delete(); i1_q.delete(); i2_q.delete();
        for (int n = 0; n < budget; n++) begin
            if (cmd[i] != 3'b000) begin
                cmd_q.push_back(cmd[i]);
                i0_q.push_back(inp[i][0]);
                i1_q.push_back(inp[i][1]);
                i2_q.push_back(inp[i][2]);
            end else if ((inp[i][0] | inp[i][1] | inp[i][2]) != 32'h0) begin
                bad++;
            end
            if (!(cmd[i] inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b111})) bad++;
            if (wv[i] && pe_ready) begin
                nhs++;
                last_row = wr[i];
                last_col = wc[i];
            end
            if (dn[i]) begin
                got_done = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_done_seen"}, 32'(got_done), 1);
        chk({tag, "_cmd_legal"}, 32'(bad), 0);
        if (got_done) begin
            chk({tag, "_busy_at_done"}, 32'(bsy[i]), 0);
            if (restart) st[i] = 1'b1;
            tick();
            st[i] = 1'b0;
            chk({tag, "_done_pulse"}, 32'(dn[i]), 0);
            if (restart) chk({tag, "_restart_ren"}, 32'(ren[i]), 1);
        end
    endtask

    task automatic exp_issue(input string tag, input int idx, input logic [2:0] c,
                             input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        if (idx < cmd_q.size()) begin
            chk({tag, "_cmd"}, 32'(cmd_q[idx]), 32'(c));
            chk({tag, "_in0"}, i0_q[idx], e0);
            chk({tag, "_in1"}, i1_q[idx], e1);
            chk({tag, "_in2"}, i2_q[idx], e2);
        end else begin
            chk({tag, "_missing"}, 32'(cmd_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int g = 0; g < 3; g++) st[g] = 1'b0;
        repeat (3) tick();
        chk_reset(0, "rst0");
        chk_reset(1, "rst1");
        chk_reset(2, "rst2");
        rst = 1'b0;
        tick();

        // 4x4, base 0, no stalls; restart in the done cycle
        start_scan(0, 16'h0000);
        run_to_done(0, "m44", 60, 1'b1, hs);
        chk("m44_nissue", 32'(cmd_q.size()), 4);
        chk("m44_hs", 32'(hs), 4);
        exp_issue("m44_all",   0, 3'b111, 32'h00000102, 32'h00040506, 32'h0008090A);
        exp_issue("m44_right", 1, 3'b001, 32'h00000003, 32'h00000007, 32'h0000000B);
        exp_issue("m44_down",  2, 3'b010, 32'h00000000, 32'h00000000, 32'h000D0E0F);
        exp_issue("m44_left",  3, 3'b100, 32'h00040000, 32'h00080000, 32'h000C0000);
        run_to_done(0, "m44b", 60, 1'b0, hs);
        chk("m44b_hs", 32'(hs), 4);

        // 3x3: a single window
        start_scan(1, 16'h0000);
        run_to_done(1, "m33", 60, 1'b0, hs);
        chk("m33_nissue", 32'(cmd_q.size()), 1);
        chk("m33_hs", 32'(hs), 1);
        exp_issue("m33_all", 0, 3'b111, 32'h00000102, 32'h00030405, 32'h00060708);

        // Stall: pe_ready low for 10 cycles in the first HOLD
        pe_ready = 1'b0;
        start_scan(0, 16'h0000);
        repeat (4) tick();
        for (int n = 0; n < 10; n++) begin
            chk("stall_wv", 32'(wv[0]), 1);
            chk("stall_cmd", 32'(cmd[0]), 0);
            chk("stall_ren", 32'(ren[0]), 0);
            tick();
        end
        pe_ready = 1'b1;
        chk("stall_wv_rel", 32'(wv[0]), 1);
        tick();
        chk("stall_fetch_ren", 32'(ren[0]), 1);
        chk("stall_fetch_wv", 32'(wv[0]), 0);
        chk("stall_fetch_a0", 32'(addr[0][0]), 32'h3);
        run_to_done(0, "stall", 60, 1'b0, hs);
        chk("stall_hs", 32'(hs), 3);

        // 5x4: OH=3, OW=2
        start_scan(2, 16'h0000);
        run_to_done(2, "m54", 80, 1'b0, hs);
        chk("m54_nissue", 32'(cmd_q.size()), 6);
        chk("m54_hs", 32'(hs), 6);
        exp_issue("m54_0", 0, 3'b111, 32'h00000102, 32'h00040506, 32'h0008090A);
        exp_issue("m54_1", 1, 3'b001, 32'h00000003, 32'h00000007, 32'h0000000B);
        exp_issue("m54_2", 2, 3'b010, 32'h00000000, 32'h00000000, 32'h000D0E0F);
        exp_issue("m54_3", 3, 3'b100, 32'h00040000, 32'h00080000, 32'h000C0000);
        exp_issue("m54_4", 4, 3'b010, 32'h00000000, 32'h00000000, 32'h00101112);
        exp_issue("m54_5", 5, 3'b001, 32'h0000000B, 32'h0000000F, 32'h00000013);
        chk("m54_last_row", 32'(last_row), 2);
        chk("m54_last_col", 32'(last_col), 1);

        // Address wrap, and a start pulse while busy with a different base
        start_scan(0, 16'hFFFE);
        check_first(0, "wrap", 16'hFFFE, 16'h0002, 16'h0006,
                    32'h00000102, 32'h00040506, 32'h0008090A);
        base_addr = 16'h1234;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        chk("wrap_fetch_a0", 32'(addr[0][0]), 32'h0001);
        run_to_done(0, "wrap", 60, 1'b0, hs);
        chk("wrap_nissue", 32'(cmd_q.size()), 3);
        chk("wrap_hs", 32'(hs), 3);
        exp_issue("wrap_right", 0, 3'b001, 32'h00000003, 32'h00000007, 32'h0000000B);
        exp_issue("wrap_down",  1, 3'b010, 32'h00000000, 32'h00000000, 32'h000D0E0F);
        exp_issue("wrap_left",  2, 3'b100, 32'h00040000, 32'h00080000, 32'h000C0000);

        // Reset in cycle 2 of LOAD, then a clean restart
        start_scan(0, 16'h0000);
        tick();
        rst = 1'b1;
        tick();
        chk_reset(0, "mrst");
        rst = 1'b0;
        start_scan(0, 16'h0000);
        check_first(0, "rfirst", 16'h0000, 16'h0004, 16'h0008,
                    32'h00000102, 32'h00040506, 32'h0008090A);
        run_to_done(0, "rfirst", 60, 1'b0, hs);
        chk("rfirst_hs", 32'(hs), 4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
